shiftin_rx: RTL and testbench
=============================

SHIFTIN_RX -- requirements
Module: shiftin_rx

Interface
REQ-001 Parameter WIDTH, default 16: number of bits per frame and width of data_o.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per serial input; legal range 2..4.
REQ-003 Port clk_i  input  1: system clock; all logic on rising edge.
REQ-004 Port reset_ni  input  1: reset, synchronous and active-low.
REQ-005 Port ser_i  input  1: serial data line, asynchronous to clk_i.
REQ-006 Port sclk_i  input  1: shift clock line, asynchronous to clk_i; data captured on its rising edge.
REQ-007 Port lclk_i  input  1: latch clock line, asynchronous to clk_i; frame transferred to output on its rising edge.
REQ-008 Port data_o  output  WIDTH: last accepted frame, MSB = first bit shifted in.
REQ-009 Port data_rdy_o  output  1: one-cycle pulse when data_o takes a new frame.
REQ-010 Port frame_err_o  output  1: one-cycle pulse on a rejected frame (see Configuration).

Function
REQ-011 The block shall pass ser_i, sclk_i and lclk_i each through SYNC_STAGES flops, then one history flop per clock line for edge detection.
REQ-012 A rising edge shall be detected when the synchronized level is 1, the history level is 0, and that line is armed.
REQ-013 A clock line shall become armed on the first cycle its synchronized level is 0 after reset; before that, no edges on that line are detected.
REQ-014 On a detected sclk rising edge the shift register shall shift left by one, taking the synchronized ser_i into bit 0 (MSB-first framing).
REQ-015 Bit counter shall increment on each sclk edge and saturate at WIDTH+1; more than WIDTH bits keep only the last WIDTH bits.
REQ-016 On a detected lclk rising edge an accepted frame shall load data_o from the shift register and pulse data_rdy_o high for exactly one cycle.
REQ-017 Latency: from the clk_i edge that first samples lclk_i high to data_rdy_o high shall be SYNC_STAGES+1 cycles.
REQ-018 sclk and lclk edges detected in the same cycle: shift first, latched frame includes the new bit and counts it.
REQ-019 Every lclk edge, accepted or rejected, shall clear the bit counter; the shift register is not cleared.
REQ-020 data_o shall hold its value between accepted frames.
REQ-021 Correct operation requires sclk_i and lclk_i high and low times each >= SYNC_STAGES+1 clk_i cycles; shorter pulses are unspecified.

Reset
REQ-022 While reset_ni is 0 at a clk_i edge: data_o=0, data_rdy_o=0, frame_err_o=0, shift register=0, counter=0, synchronizer and history flops=0, both lines disarmed.
REQ-023 Reset asserted mid-frame shall discard all shifted bits; no data_rdy_o or frame_err_o pulse results from the aborted frame.

Configuration
REQ-024 Macro SHIFTIN_FRAME_CHECK_EN defined: lclk edge with counter != WIDTH shall be rejected -- data_o unchanged, data_rdy_o stays 0, frame_err_o pulses high one cycle.
REQ-025 Macro SHIFTIN_FRAME_CHECK_EN undefined: every lclk edge is accepted regardless of count, and frame_err_o is tied 0.

Verification
REQ-026 Reset then 16 sclk bits of 0x2A5C MSB-first, then lclk -> data_o=0x2A5C, data_rdy_o one-cycle pulse 3 cycles after lclk sampled high.
REQ-027 sclk_i and lclk_i held high through reset release, then low, then frame 0x0001 -> no spurious shift before arming, data_o=0x0001.
REQ-028 18 bits 0b11 followed by 0xBEEF, then lclk -> data_o=0xBEEF; with SHIFTIN_FRAME_CHECK_EN: frame_err_o=1, data_o unchanged, no data_rdy_o.
REQ-029 15 bits then sclk and lclk rising together with 16th bit=1, frame 0x8001 -> data_o=0x8001, data_rdy_o pulse, frame_err_o=0 in both configurations.
REQ-030 Reset asserted after 8 bits of 0xFFFF, then new frame 0x1234 -> data_o=0x1234, exactly one data_rdy_o pulse after reset.
REQ-031 With SHIFTIN_FRAME_CHECK_EN, 12 bits then lclk -> frame_err_o pulse, data_o=0; next full frame 0x00FF -> accepted, data_o=0x00FF.

Source files
------------

// File: rtl/shiftin_rx_if.sv
// Serial-in receiver bus: three asynchronous serial lines in, one parallel frame out.
// Handshake: data_rdy_o is a one-cycle valid pulse with no ready; data_o is held between pulses.
interface shiftin_rx_if #(
    parameter int WIDTH = 16
);
    logic             ser_i;
    logic             sclk_i;
    logic             lclk_i;
    logic [WIDTH-1:0] data_o;
    logic             data_rdy_o;
    logic             frame_err_o;

    modport master (
        output ser_i, sclk_i, lclk_i,
        input  data_o, data_rdy_o, frame_err_o
    );

    modport slave (
        input  ser_i, sclk_i, lclk_i,
        output data_o, data_rdy_o, frame_err_o
    );
endinterface

// File: rtl/shiftin_rx.sv
// MSB-first serial frame receiver with synchronized shift/latch clock lines.
// Optional frame length check: define SHIFTIN_FRAME_CHECK_EN to reject frames whose bit count != WIDTH.
module shiftin_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic         clk_i,
    input logic         reset_ni,
    shiftin_rx_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);

    logic [SYNC_STAGES-1:0] ser_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lclk_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_hist;
    logic                   lclk_hist;
    logic                   sclk_armed;
    logic                   lclk_armed;
    logic [WIDTH-1:0]       shift_q;
    logic [WIDTH-1:0]       data_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_bit;
    logic                   load_q;
    logic                   data_rdy_q;
    logic                   ser_s;
    logic                   sclk_s;
    logic                   lclk_s;
    logic                   settled;
    logic                   sclk_rise;
    logic                   lclk_rise;
    logic                   accept;

    assign ser_s   = ser_sync[SYNC_STAGES-1];
    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign lclk_s  = lclk_sync[SYNC_STAGES-1];
    // The reset-cleared synchronizer zeros are not real samples; arm only once real samples emerge.
    assign settled = fill[SYNC_STAGES-1];

    always_comb begin
        sclk_rise = sclk_s & ~sclk_hist & sclk_armed;
        lclk_rise = lclk_s & ~lclk_hist & lclk_armed;
        count_bit = count_q;
        if (sclk_rise && (count_q != CNT_SAT)) begin
            count_bit = count_q + 1'b1;
        end
`ifdef SHIFTIN_FRAME_CHECK_EN
        accept = (count_bit == CNT_FULL);
`else
        accept = 1'b1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            ser_sync   <= '0;
            sclk_sync  <= '0;
            lclk_sync  <= '0;
            fill       <= '0;
            sclk_hist  <= 1'b0;
            lclk_hist  <= 1'b0;
            sclk_armed <= 1'b0;
            lclk_armed <= 1'b0;
            shift_q    <= '0;
            count_q    <= '0;
            load_q     <= 1'b0;
            data_rdy_q <= 1'b0;
            data_q     <= '0;
        end else begin
            ser_sync   <= {ser_sync[SYNC_STAGES-2:0], bus.ser_i};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
            lclk_sync  <= {lclk_sync[SYNC_STAGES-2:0], bus.lclk_i};
            fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_hist  <= sclk_s;
            lclk_hist  <= lclk_s;
            sclk_armed <= sclk_armed | (settled & ~sclk_s);
            lclk_armed <= lclk_armed | (settled & ~lclk_s);
            if (sclk_rise) begin
                shift_q <= (shift_q << 1) | WIDTH'(ser_s);
            end
            count_q    <= lclk_rise ? '0 : count_bit;
            // Latch is staged one cycle so a same-cycle sclk bit is already in shift_q.
            load_q     <= lclk_rise & accept;
            data_rdy_q <= load_q;
            if (load_q) begin
                data_q <= shift_q;
            end
        end
    end

`ifdef SHIFTIN_FRAME_CHECK_EN
    logic reject_q;
    logic frame_err_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            reject_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            reject_q    <= lclk_rise & ~accept;
            frame_err_q <= reject_q;
        end
    end

    assign bus.frame_err_o = frame_err_q;
`else
    assign bus.frame_err_o = 1'b0;
`endif

    assign bus.data_o     = data_q;
    assign bus.data_rdy_o = data_rdy_q;
endmodule

// File: tb/tb_shiftin_rx.sv
// Bench for shiftin_rx: directed frames plus random frames against a bit-history reference model.
module tb_shiftin_rx;
    localparam int WIDTH = 16;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    shiftin_rx_if #(.WIDTH(WIDTH)) bus ();

    shiftin_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every bit shifted since reset, bits since last latch, expected results.
    bit               hist[$];
    int               n_bits = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_data = '0;
    int               exp_rdy = 0;
    int               exp_err = 0;
    int               rdy_cnt = 0;
    int               err_cnt = 0;
    logic             prev_rdy = 1'b0;
    logic             prev_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] frame_val();
        logic [WIDTH-1:0] v = '0;
        int sz = hist.size();
        for (int i = 0; i < WIDTH; i++) begin
            if (sz - 1 - i >= 0) v[i] = hist[sz-1-i];
        end
        return v;
    endfunction

    task automatic model_latch();
        bit ok;
`ifdef SHIFTIN_FRAME_CHECK_EN
        ok = (n_bits == WIDTH);
`else
        ok = 1'b1;
`endif
        if (ok) begin
            exp_data = frame_val();
            exp_q.push_back(exp_data);
            exp_rdy++;
        end else begin
            exp_err++;
        end
        n_bits = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold();
        wait_cyc($urandom_range(SYNC + 1, SYNC + 3));
    endtask

    task automatic send_bit(input bit b);
        bus.ser_i = b;
        hold();
        bus.sclk_i = 1'b1;
        hist.push_back(b);
        n_bits++;
        hold();
        bus.sclk_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic latch(input bit with_bit, input bit b);
        if (with_bit) begin
            bus.ser_i = b;
            hold();
            bus.sclk_i = 1'b1;
            hist.push_back(b);
            n_bits++;
        end else begin
            hold();
        end
        bus.lclk_i = 1'b1;
        model_latch();
        hold();
        bus.sclk_i = 1'b0;
        bus.lclk_i = 1'b0;
        hold();
        wait_cyc(4);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_rdy_count"}, rdy_cnt, exp_rdy);
        chk({tag, "_err_count"}, err_cnt, exp_err);
        chk({tag, "_data"}, bus.data_o, exp_data);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_cyc(3);
        chk("reset_data", bus.data_o, 0);
        chk("reset_rdy", bus.data_rdy_o, 0);
        chk("reset_err", bus.frame_err_o, 0);
        hist.delete();
        exp_q.delete();
        n_bits = 0;
        exp_data = '0;
        exp_rdy = 0;
        exp_err = 0;
        rdy_cnt = 0;
        err_cnt = 0;
        reset_n = 1'b1;
    endtask

    // Output monitor and scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_rdy = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (bus.data_rdy_o) begin
                rdy_cnt++;
                chk("rdy_pulse_width", prev_rdy, 0);
                if (exp_q.size() == 0) chk("rdy_unexpected", 1, 0);
                else chk("rdy_data", bus.data_o, exp_q.pop_front());
            end
            if (bus.frame_err_o) begin
                err_cnt++;
                chk("err_pulse_width", prev_err, 0);
            end
            prev_rdy = bus.data_rdy_o;
            prev_err = bus.frame_err_o;
        end
    end

    initial begin
        bus.ser_i  = 1'b0;
        bus.sclk_i = 1'b1;
        bus.lclk_i = 1'b1;
        wait_cyc(2);

        // Clock lines high through reset release: nothing may happen before they go low.
        do_reset();
        wait_cyc(10);
        check_state("pre_arm");
        bus.sclk_i = 1'b0;
        bus.lclk_i = 1'b0;
        wait_cyc(5);
        send_word(32'h0001, WIDTH);
        latch(1'b0, 1'b0);
        check_state("arm_0001");

        // Latency from lclk sampling edge to data_rdy_o.
        do_reset();
        wait_cyc(5);
        send_word(32'h2A5C, WIDTH);
        wait_cyc(SYNC + 2);
        bus.lclk_i = 1'b1;
        model_latch();
        for (int c = 1; c <= SYNC + 2; c++) begin
            @(negedge clk);
            chk($sformatf("latency_c%0d", c), bus.data_rdy_o, (c == SYNC + 2) ? 1 : 0);
        end
        @(negedge clk);
        chk("latency_after", bus.data_rdy_o, 0);
        wait_cyc(SYNC + 1);
        bus.lclk_i = 1'b0;
        wait_cyc(SYNC + 5);
        check_state("frame_2a5c");

        // Overlong frame.
        send_word(32'h3, 2);
        send_word(32'hBEEF, WIDTH);
        latch(1'b0, 1'b0);
        check_state("overlong_beef");

        // 16th bit shifted in the same cycle as the latch edge.
        send_word(32'h8001 >> 1, WIDTH - 1);
        latch(1'b1, 1'b1);
        check_state("same_cycle_8001");

        // Reset mid-frame discards the partial frame.
        send_word(32'hFF, 8);
        do_reset();
        wait_cyc(4);
        send_word(32'h1234, WIDTH);
        latch(1'b0, 1'b0);
        check_state("after_reset_1234");

        // Short frame, then a full one.
        do_reset();
        wait_cyc(4);
        send_word(32'hABC, 12);
        latch(1'b0, 1'b0);
        check_state("short_12");
        send_word(32'h00FF, WIDTH);
        latch(1'b0, 1'b0);
        check_state("full_00ff");

        // Random frames, mostly full length, some short/long, some with a same-cycle last bit.
        for (int f = 0; f < 24; f++) begin
            int          n;
            logic [31:0] v;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(8, WIDTH + 3) : WIDTH;
            v = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                send_word(v >> 1, n - 1);
                latch(1'b1, v[0]);
            end else begin
                send_word(v, n);
                latch(1'b0, 1'b0);
            end
            check_state($sformatf("rand_%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
